// File: rtl/spike_encoder_array.sv
// Multi-channel temporal spike encoder: latches per-channel spike times on start and
// replays them across one PERIOD-cycle window in sustained or single-pulse form.
module spike_encoder_array #(
    parameter int NUM_CH = 8,
    parameter int TIME_W = 4,
    parameter int PERIOD = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       mode,
    input  logic [NUM_CH*TIME_W-1:0]   spike_times,
    input  logic [NUM_CH-1:0]          inhibit,
    output logic [NUM_CH-1:0]          spike_out,
    output logic [TIME_W-1:0]          time_val,
    output logic                       busy,
    output logic                       window_done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [TIME_W-1:0] LAST_T = TIME_W'(PERIOD - 1);

    state_t                     state_r, state_s;
    logic [TIME_W-1:0]          time_r, time_s;
    logic [NUM_CH*TIME_W-1:0]   times_r, times_s;
    logic [NUM_CH-1:0]          inh_r, inh_s;
    logic                       mode_r, mode_s;
    logic                       done_r, done_s;
    logic                       busy_r;
    logic [NUM_CH-1:0]          spike_r, spike_s;
    logic                       latch_s;
    logic [TIME_W-1:0]          ch_time_s;

    // Next-state, window counter and input-latch decision.
    always_comb begin
        state_s = state_r;
        time_s  = time_r;
        done_s  = 1'b0;
        latch_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                time_s = {TIME_W{1'b0}};
                if (start && !abort) begin
                    state_s = ST_RUN;
                    latch_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    time_s  = {TIME_W{1'b0}};
                end else if (time_r == LAST_T) begin
                    done_s = 1'b1;
                    time_s = {TIME_W{1'b0}};
                    if (start) begin
                        latch_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    time_s = time_r + TIME_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                time_s  = {TIME_W{1'b0}};
            end
        endcase
    end

    // Select freshly latched or held window parameters.
    always_comb begin
        if (latch_s) begin
            times_s = spike_times;
            inh_s   = inhibit;
            mode_s  = mode;
        end else begin
            times_s = times_r;
            inh_s   = inh_r;
            mode_s  = mode_r;
        end
    end

    // Spike decode from next-cycle state so spike_out can be a plain register.
    always_comb begin
        spike_s   = {NUM_CH{1'b0}};
        ch_time_s = {TIME_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            ch_time_s = times_s[i*TIME_W +: TIME_W];
            if ((state_s == ST_RUN) && !inh_s[i]) begin
                if (mode_s) begin
                    spike_s[i] = (ch_time_s == time_s);
                end else begin
                    spike_s[i] = (ch_time_s <= time_s);
                end
            end else begin
                spike_s[i] = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            time_r  <= {TIME_W{1'b0}};
            times_r <= {(NUM_CH*TIME_W){1'b0}};
            inh_r   <= {NUM_CH{1'b0}};
            mode_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            spike_r <= {NUM_CH{1'b0}};
        end else begin
            state_r <= state_s;
            time_r  <= time_s;
            times_r <= times_s;
            inh_r   <= inh_s;
            mode_r  <= mode_s;
            done_r  <= done_s;
            busy_r  <= (state_s == ST_RUN);
            spike_r <= spike_s;
        end
    end

    assign spike_out   = spike_r;
    assign time_val    = time_r;
    assign busy        = busy_r;
    assign window_done = done_r;

endmodule

// File: tb/tb_spike_encoder_array.sv
// Randomised bench for spike_encoder_array with a window-level reference model and
// directed literal checks for the sustained, pulse, back-to-back, abort and reset cases.
module tb_spike_encoder_array;

    localparam int NUM_CH = 4;
    localparam int TIME_W = 4;
    localparam int PERIOD = 10;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic                     abort = 1'b0;
    logic                     mode = 1'b0;
    logic [NUM_CH*TIME_W-1:0] spike_times = '0;
    logic [NUM_CH-1:0]        inhibit = '0;
    logic [NUM_CH-1:0]        spike_out;
    logic [TIME_W-1:0]        time_val;
    logic                     busy;
    logic                     window_done;

    int vectors = 0;
    int miscompares = 0;

    spike_encoder_array #(.NUM_CH(NUM_CH), .TIME_W(TIME_W), .PERIOD(PERIOD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .spike_times(spike_times), .inhibit(inhibit), .spike_out(spike_out),
        .time_val(time_val), .busy(busy), .window_done(window_done)
    );

    always #5 clk = ~clk;

    // Reference model: a window is "in progress" with an integer step count;
    // the parameters of the window are kept as plain integers.
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    int   m_step = 0;
    int   m_times [NUM_CH];
    bit   m_inh [NUM_CH];
    bit   m_pulse = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_step  <= 0;
            m_pulse <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_times[i] <= 0;
                m_inh[i]   <= 1'b0;
            end
        end else begin
            m_done <= m_busy && !abort && (m_step == PERIOD - 1);
            if ((!m_busy && start && !abort) ||
                (m_busy && !abort && m_step == PERIOD - 1 && start)) begin
                m_busy  <= 1'b1;
                m_step  <= 0;
                m_pulse <= mode;
                for (int i = 0; i < NUM_CH; i++) begin
                    m_times[i] <= int'(spike_times[i*TIME_W +: TIME_W]);
                    m_inh[i]   <= inhibit[i];
                end
            end else if (m_busy && !abort && m_step < PERIOD - 1) begin
                m_step <= m_step + 1;
            end else begin
                m_busy <= 1'b0;
                m_step <= 0;
            end
        end
    end

    function automatic logic [NUM_CH-1:0] model_spikes();
        logic [NUM_CH-1:0] s;
        s = '0;
        if (m_busy) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!m_inh[i] && m_times[i] < PERIOD) begin
                    s[i] = m_pulse ? (m_times[i] == m_step) : (m_times[i] <= m_step);
                end
            end
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("model_spike_out", 32'(spike_out), 32'(model_spikes()));
        check("model_time_val", 32'(time_val), m_busy ? 32'(m_step) : 32'd0);
        check("model_busy", 32'(busy), 32'(m_busy));
        check("model_window_done", 32'(window_done), 32'(m_done));
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_time"}, 32'(time_val), 32'd0);
        check({tag, "_spike"}, 32'(spike_out), 32'd0);
        check({tag, "_done"}, 32'(window_done), 32'd0);
    endtask

    initial begin
        tick(2);
        check_idle("reset");
        rst_n = 1'b1;
        tick(2);
        check_idle("post_reset");

        // Sustained window, times {0,3,9,12}, with an ignored start at t=4.
        spike_times = {4'd12, 4'd9, 4'd3, 4'd0};
        inhibit = 4'b0000; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("sus_t0_spike", 32'(spike_out), 32'h1);
        check("sus_t0_busy", 32'(busy), 32'd1);
        tick(3);
        check("sus_t3_spike", 32'(spike_out), 32'h3);
        check("sus_t3_time", 32'(time_val), 32'd3);
        tick();
        start = 1'b1; spike_times = 16'hFFFF;
        tick();
        start = 1'b0; spike_times = 16'(($urandom));
        tick(4);
        check("sus_t9_spike", 32'(spike_out), 32'h7);
        check("sus_t9_time", 32'(time_val), 32'd9);
        tick();
        check("sus_done", 32'(window_done), 32'd1);
        check("sus_end_busy", 32'(busy), 32'd0);
        check("sus_end_spike", 32'(spike_out), 32'd0);
        tick();
        check("sus_done_once", 32'(window_done), 32'd0);

        // Pulse window, times {2,2,7,15}, ch1 inhibited; back-to-back at t=9.
        spike_times = {4'd15, 4'd7, 4'd2, 4'd2};
        inhibit = 4'b0010; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("pul_t0_spike", 32'(spike_out), 32'h0);
        tick(2);
        check("pul_t2_spike", 32'(spike_out), 32'h1);
        tick();
        check("pul_t3_spike", 32'(spike_out), 32'h0);
        tick(4);
        check("pul_t7_spike", 32'(spike_out), 32'h4);
        tick(2);
        check("pul_t9_spike", 32'(spike_out), 32'h0);
        spike_times = 16'h1111; inhibit = 4'b0000; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_time", 32'(time_val), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done", 32'(window_done), 32'd1);
        check("b2b_t0_spike", 32'(spike_out), 32'h0);
        tick();
        check("b2b_t1_spike", 32'(spike_out), 32'hF);

        // Abort at t=6 with a coincident start, then a fresh window.
        tick(5);
        check("abt_t6_time", 32'(time_val), 32'd6);
        abort = 1'b1; start = 1'b1;
        tick();
        check_idle("abort");
        abort = 1'b0; spike_times = 16'h0000;
        tick();
        start = 1'b0;
        check("fresh_time", 32'(time_val), 32'd0);
        check("fresh_spike", 32'(spike_out), 32'hF);

        // Reset at t=5 of a running window.
        tick(5);
        check("rst_t5_time", 32'(time_val), 32'd5);
        rst_n = 1'b0;
        #1;
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_time", 32'(time_val), 32'd0);
        check("rst_async_spike", 32'(spike_out), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check_idle("rst_release");

        // Random traffic, occasionally resetting.
        for (int c = 0; c < 3000; c++) begin
            start       = ($urandom_range(0, 3) == 0);
            abort       = ($urandom_range(0, 19) == 0);
            mode        = 1'($urandom);
            spike_times = 16'($urandom);
            inhibit     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            rst_n       = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
